pattern_detector4: RTL and testbench

// - Byte-stream sequence detector. Scans an 8-bit data stream, one byte per accepted clock.
// - Flags when the last four accepted bytes equal a fixed 4-byte pattern.
// - Holds the flag until the downstream consumer acknowledges by dropping ack.
// - Sits between a byte source (e.g. a file or FIFO reader) and control logic that must react to the pattern.
//

---
 rtl/pattern_detector4.sv | 92 +++++++++
 tb/tb_pattern_detector4.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector4.sv
// pattern_detector4 -- byte-stream detector for a fixed 4-byte sequence.
//
// Scans one byte per accepted clock and raises found_pattern when the last four
// accepted bytes equal PATTERN (byte 0 = PATTERN[31:24] arrives first). The flag
// is held until the consumer drops ack for one clock. Matching is KMP-style, so
// overlapping prefixes are tracked, but a reported match is not reused.
//
// Ports:
//   clk            in   1  clock, rising edge
//   reset_sync     in   1  asynchronous active-high reset
//   data           in   8  stream byte, taken when ack=1 and no match pending
//   ack            in   1  1 = byte valid / consumer ready; 0 = stall or acknowledge
//   found_pattern  out  1  registered; 1 while a detected match awaits acknowledge
module pattern_detector4 #(
  parameter logic [31:0] PATTERN = 32'hA5A5_5AC3
) (
  input  logic       clk,
  input  logic       reset_sync,
  input  logic [7:0] data,
  input  logic       ack,
  output logic       found_pattern
);

  // Encoding equals the number of matched pattern bytes.
  typedef enum logic [2:0] {
    StM0    = 3'd0,
    StM1    = 3'd1,
    StM2    = 3'd2,
    StM3    = 3'd3,
    StFound = 3'd4
  } state_t;

  state_t      state_q, state_d, next_m;
  logic [23:0] hist_q, hist_d;  // last three accepted bytes, [7:0] newest
  logic [31:0] recent;          // candidate stream tail: history plus incoming byte
  logic [4:1]  sfx_ok;          // sfx_ok[j]: last j bytes of recent equal pattern bytes 0..j-1

  assign recent = {hist_q, data};

  // recent byte m (0 = incoming) must equal pattern byte j-1-m.
  for (genvar j = 1; j <= 4; j++) begin : g_sfx
    logic [j-1:0] eq;
    for (genvar m = 0; m < j; m++) begin : g_byte
      assign eq[m] = (recent[8*m +: 8] == PATTERN[8*(4-j+m) +: 8]);
    end
    assign sfx_ok[j] = &eq;
  end

  // Longest prefix reachable from state k is at most k+1 bytes, which also keeps
  // history older than the current partial match out of the decision.
  always_comb begin
    next_m = StM0;
    if (sfx_ok[1])                      next_m = StM1;
    if (sfx_ok[2] && state_q >= StM1)   next_m = StM2;
    if (sfx_ok[3] && state_q >= StM2)   next_m = StM3;
    if (sfx_ok[4] && state_q == StM3)   next_m = StFound;
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    case (state_q)
      StFound: begin
        // Acknowledge: drop the match and forget its bytes.
        if (!ack) begin
          state_d = StM0;
          hist_d  = '0;
        end
      end
      default: begin
        if (ack) begin
          state_d = next_m;
          hist_d  = {hist_q[15:0], data};
        end
      end
    endcase
  end

  // Clearing history on entry to FOUND is unnecessary: M0 never consults it.
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      state_q <= StM0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
    end
  end

  assign found_pattern = (state_q == StFound);

endmodule

// File: tb/tb_pattern_detector4.sv
module tb_pattern_detector4;

  localparam logic [31:0] PAT = 32'hA5A5_5AC3;

  logic       clk = 1'b0;
  logic       reset_sync;
  logic [7:0] data;
  logic       ack;
  logic       found_pattern;

  int n_tests = 0;
  int n_fail  = 0;

  pattern_detector4 #(.PATTERN(PAT)) dut (
    .clk           (clk),
    .reset_sync    (reset_sync),
    .data          (data),
    .ack           (ack),
    .found_pattern (found_pattern)
  );

  always #5 clk = ~clk;

  // Reference model: bytes accepted since the last clear; a match is the stream
  // tail equalling the pattern, after which the consumed bytes are forgotten.
  logic [7:0] m_bytes[$];
  bit         m_found;

  function automatic bit tail_matches(input logic [7:0] d);
    logic [31:0] w;
    if (m_bytes.size() < 3) return 1'b0;
    w = {m_bytes[m_bytes.size()-3], m_bytes[m_bytes.size()-2], m_bytes[m_bytes.size()-1], d};
    return w == PAT;
  endfunction

  function automatic void model_clear();
    m_bytes.delete();
    m_found = 1'b0;
  endfunction

  function automatic void model_step(input logic a, input logic [7:0] d);
    if (m_found) begin
      if (!a) model_clear();
    end else if (a) begin
      if (tail_matches(d)) begin
        m_bytes.delete();
        m_found = 1'b1;
      end else begin
        m_bytes.push_back(d);
        if (m_bytes.size() > 3) void'(m_bytes.pop_front());
      end
    end
  endfunction

  task automatic chk(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: found_pattern=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic tick(input logic a, input logic [7:0] d);
    ack  = a;
    data = d;
    model_step(a, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       ack;
    logic [7:0] data;
    logic       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic a, input logic [7:0] d, input logic e);
    vec_t v;
    v.ack = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] d;
    logic       a;

    // Basic: 00 A5 A5 5A C3
    add(1, 8'h00, 0); add(1, 8'hA5, 0); add(1, 8'hA5, 0); add(1, 8'h5A, 0); add(1, 8'hC3, 1);
    // Hold with ack=1; data ignored
    add(1, 8'hA5, 1); add(1, 8'hA5, 1); add(1, 8'h5A, 1);
    // Acknowledge, then detect again
    add(0, 8'hC3, 0);
    add(1, 8'hA5, 0); add(1, 8'hA5, 0); add(1, 8'h5A, 0); add(1, 8'hC3, 1); add(0, 8'h00, 0);
    // Overlap fallback: A5 A5 A5 5A C3
    add(1, 8'hA5, 0); add(1, 8'hA5, 0); add(1, 8'hA5, 0); add(1, 8'h5A, 0); add(1, 8'hC3, 1);
    add(0, 8'h00, 0);
    // A5 A5 5A A5 A5 5A C3
    add(1, 8'hA5, 0); add(1, 8'hA5, 0); add(1, 8'h5A, 0); add(1, 8'hA5, 0);
    add(1, 8'hA5, 0); add(1, 8'h5A, 0); add(1, 8'hC3, 1); add(0, 8'h00, 0);
    // Stall with 5A on data
    add(1, 8'hA5, 0); add(1, 8'hA5, 0); add(0, 8'h5A, 0); add(0, 8'h5A, 0);
    add(1, 8'h5A, 0); add(1, 8'hC3, 1); add(0, 8'h00, 0);
    // Matched bytes are not reused: 5A C3 right after an acknowledge
    add(1, 8'h5A, 0); add(1, 8'hC3, 0);

    reset_sync = 1'b1;
    ack        = 1'b0;
    data       = 8'h00;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", found_pattern, 1'b0);
    reset_sync = 1'b0;

    foreach (vecs[i]) begin
      tick(vecs[i].ack, vecs[i].data);
      chk($sformatf("vec%0d", i), found_pattern, vecs[i].exp);
    end

    // Asynchronous reset in M2, then a partial continuation must not detect.
    tick(0, 8'h00);
    tick(1, 8'hA5);
    tick(1, 8'hA5);
    #2 reset_sync = 1'b1;
    #1 chk("rst_in_m2", found_pattern, 1'b0);
    model_clear();
    @(negedge clk);
    reset_sync = 1'b0;
    tick(1, 8'h5A); chk("rst_discard_a", found_pattern, 1'b0);
    tick(1, 8'hC3); chk("rst_discard_b", found_pattern, 1'b0);
    tick(1, 8'hA5); tick(1, 8'hA5); tick(1, 8'h5A);
    chk("post_rst_pre", found_pattern, 1'b0);
    tick(1, 8'hC3); chk("post_rst_detect", found_pattern, 1'b1);

    // Asynchronous reset while in FOUND clears the flag before any edge.
    #2 reset_sync = 1'b1;
    #1 chk("rst_in_found", found_pattern, 1'b0);
    model_clear();
    @(negedge clk);
    reset_sync = 1'b0;
    tick(1, 8'hA5); tick(1, 8'hA5); tick(1, 8'h5A); tick(1, 8'hC3);
    chk("post_rst2_detect", found_pattern, 1'b1);
    tick(0, 8'h00);
    chk("ack_clear", found_pattern, 1'b0);

    // No false hit: 32 random bytes steered away from completing the pattern.
    for (int i = 0; i < 32; i++) begin
      case ($urandom_range(0, 4))
        0:       d = 8'hA5;
        1:       d = 8'h5A;
        2:       d = 8'hC3;
        3:       d = 8'hA5;
        default: d = 8'($urandom);
      endcase
      if (tail_matches(d)) d = 8'h00;
      tick(1, d);
      chk($sformatf("nohit%0d", i), found_pattern, 1'b0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    d = 8'hA5;
        2:       d = 8'h5A;
        3:       d = 8'hC3;
        default: d = 8'($urandom);
      endcase
      a = ($urandom_range(0, 9) < 7);
      tick(a, d);
      chk($sformatf("rand%0d", i), found_pattern, m_found);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
